// File: rtl/yarp_imem_responder.sv
// Instruction-memory responder: word reads from fetch returned after LATENCY cycles
// through a valid-tagged pipeline; storage is preloaded through a dedicated load port.
module yarp_imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_mem_req_i,
    input  logic [31:0] instr_mem_addr_i,
    output logic        req_ready_o,
    input  logic        hold_i,
    output logic [31:0] mem_rd_data_o,
    output logic        rsp_valid_o,
    output logic        rsp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
    output logic        load_err_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);

    typedef struct packed {
        logic             err;
        logic [IDX_W-1:0] idx;
    } dec_t;

    // Byte address -> word index; the 33-bit subtraction exposes addresses below the base.
    function automatic dec_t decode(input logic [31:0] addr);
        logic [32:0] off;
        dec_t        d;
        off   = {1'b0, addr} - {1'b0, BASE_ADDR};
        d.idx = off[IDX_W+1:2];
        d.err = off[32] || (off[1:0] != 2'b00) ||
                ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));
        return d;
    endfunction

    logic [DATA_W-1:0]  mem_q [DEPTH_WORDS];
    logic [LATENCY-1:0] valid_q, valid_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];
    logic               load_err_q;

    dec_t req_dec;
    dec_t load_dec;
    logic accept;

    assign req_dec     = decode(instr_mem_addr_i);
    assign load_dec    = decode(load_addr_i);
    assign req_ready_o = !load_en_i && !hold_i;
    assign accept      = instr_mem_req_i && req_ready_o;

    // Pipeline advance; a stage's data only changes when a valid entry moves in,
    // so the last stage naturally holds the most recent response word.
    always_comb begin
        valid_d = valid_q;
        err_d   = err_q;
        data_d  = data_q;
        if (!hold_i) begin
            valid_d[0] = accept;
            err_d[0]   = accept && req_dec.err;
            if (accept) begin
                data_d[0] = req_dec.err ? NOP_INSTR : mem_q[req_dec.idx];
            end
            for (int i = 1; i < int'(LATENCY); i++) begin
                valid_d[i] = valid_q[i-1];
                err_d[i]   = valid_q[i-1] && err_q[i-1];
                if (valid_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= '0;
            err_q      <= '0;
            load_err_q <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                data_q[i] <= NOP_INSTR;
            end
        end else begin
            valid_q <= valid_d;
            err_q   <= err_d;
            data_q  <= data_d;
            if (load_en_i && load_dec.err) begin
                load_err_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately outside reset so preloaded code survives a reset.
    always_ff @(posedge clk) begin
        if (load_en_i && !load_dec.err) begin
            mem_q[load_dec.idx] <= load_data_i;
        end
    end

    assign rsp_valid_o   = valid_q[LATENCY-1];
    assign rsp_err_o     = err_q[LATENCY-1];
    assign mem_rd_data_o = data_q[LATENCY-1];
    assign load_err_o    = load_err_q;

endmodule

// File: tb/tb_yarp_imem_responder.sv
// Bench for yarp_imem_responder: three instances (LATENCY 1, 2, 4) share stimulus and are
// checked each cycle against a history-based model, plus a directed vector table.
module tb_yarp_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, hold, ld;
    logic [31:0] addr, laddr, ldata;

    logic        rdy1, val1, err1, lerr1;
    logic        rdy2, val2, err2, lerr2;
    logic        rdy4, val4, err4, lerr4;
    logic [31:0] dat1, dat2, dat4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    yarp_imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1), .NOP_INSTR(NOP)) u_l1 (
        .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
        .req_ready_o(rdy1), .hold_i(hold), .mem_rd_data_o(dat1), .rsp_valid_o(val1),
        .rsp_err_o(err1), .load_en_i(ld), .load_addr_i(laddr), .load_data_i(ldata),
        .load_err_o(lerr1));

    yarp_imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(2), .NOP_INSTR(NOP)) u_l2 (
        .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
        .req_ready_o(rdy2), .hold_i(hold), .mem_rd_data_o(dat2), .rsp_valid_o(val2),
        .rsp_err_o(err2), .load_en_i(ld), .load_addr_i(laddr), .load_data_i(ldata),
        .load_err_o(lerr2));

    yarp_imem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(4), .NOP_INSTR(NOP)) u_l4 (
        .clk(clk), .reset(reset), .instr_mem_req_i(req), .instr_mem_addr_i(addr),
        .req_ready_o(rdy4), .hold_i(hold), .mem_rd_data_o(dat4), .rsp_valid_o(val4),
        .rsp_err_o(err4), .load_en_i(ld), .load_addr_i(laddr), .load_data_i(ldata),
        .load_err_o(lerr4));

    // Reference: memory image plus the list of pipeline entries, one per unfrozen cycle.
    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } ent_t;

    logic [31:0] ref_mem [DEPTH];
    ent_t        hist[$];
    logic        m_lerr;

    function automatic bit addr_bad(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (off < 0) || ((off % 4) != 0) || ((off / 4) >= longint'(DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((longint'(a) - longint'(BASE)) / 4);
    endfunction

    // Output of a LATENCY=L responder: the entry pushed L advances ago; data is the newest valid word.
    function automatic ent_t expect_out(input int L);
        ent_t r;
        r = '{v: 1'b0, e: 1'b0, d: NOP};
        if (hist.size() >= L) begin
            r.v = hist[hist.size()-L].v;
            r.e = hist[hist.size()-L].e;
        end
        for (int i = hist.size() - L; i >= 0; i--) begin
            if (hist[i].v) begin
                r.d = hist[i].d;
                break;
            end
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int L, input logic rv, input logic re, input logic [31:0] rd,
                              input logic le, input logic rr);
        ent_t x;
        x = expect_out(L);
        chk($sformatf("L%0d rsp_valid", L), 32'(rv), 32'(x.v));
        chk($sformatf("L%0d rsp_err", L), 32'(re), 32'(x.e));
        chk($sformatf("L%0d rd_data", L), rd, x.d);
        chk($sformatf("L%0d load_err", L), 32'(le), 32'(m_lerr));
        chk($sformatf("L%0d req_ready", L), 32'(rr), 32'(!ld && !hold));
    endtask

    task automatic sample();
        @(negedge clk);
        if (reset) begin
            hist.delete();
            m_lerr = 1'b0;
        end
        check_inst(1, val1, err1, dat1, lerr1, rdy1);
        check_inst(2, val2, err2, dat2, lerr2, rdy2);
        check_inst(4, val4, err4, dat4, lerr4, rdy4);
    endtask

    task automatic advance();
        ent_t e;
        if (!reset) begin
            if (!hold) begin
                e.v = req && !ld;
                e.e = e.v && addr_bad(addr);
                e.d = (!e.v || e.e) ? NOP : ref_mem[word_of(addr)];
                hist.push_back(e);
            end
            if (ld) begin
                if (addr_bad(laddr)) m_lerr = 1'b1;
                else ref_mem[word_of(laddr)] = ldata;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    typedef struct {
        logic        rq;
        logic [31:0] a;
        logic        h;
        logic        l;
        logic [31:0] la;
        logic [31:0] ldat;
        logic        x_rdy;
        logic        x_val;
        logic        x_err;
        logic [31:0] x_dat;
        logic        x_lerr;
    } vec_t;

    function automatic vec_t mk(input logic rq, input logic [31:0] a, input logic h, input logic l,
                                input logic [31:0] la, input logic [31:0] ldat, input logic r,
                                input logic v, input logic e, input logic [31:0] d, input logic le);
        vec_t t;
        t = '{rq, a, h, l, la, ldat, r, v, e, d, le};
        return t;
    endfunction

    vec_t tbl[28];

    initial begin
        int r;
        // Expected columns describe the LATENCY=2 instance as seen in that row's cycle.
        tbl[0]  = mk(0, 32'h0,    0, 1, 32'h0, 32'h11,   0, 0, 0, NOP,      0);
        tbl[1]  = mk(0, 32'h0,    0, 1, 32'h4, 32'h22,   0, 0, 0, NOP,      0);
        tbl[2]  = mk(0, 32'h0,    0, 1, 32'h8, 32'h33,   0, 0, 0, NOP,      0);
        tbl[3]  = mk(0, 32'h0,    0, 1, 32'hC, 32'h44,   0, 0, 0, NOP,      0);
        tbl[4]  = mk(1, 32'h0,    0, 0, 32'h0, 32'h0,    1, 0, 0, NOP,      0);
        tbl[5]  = mk(1, 32'h4,    0, 0, 32'h0, 32'h0,    1, 0, 0, NOP,      0);
        tbl[6]  = mk(1, 32'h8,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h11,   0);
        tbl[7]  = mk(1, 32'hC,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h22,   0);
        tbl[8]  = mk(1, 32'h6,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h33,   0);
        tbl[9]  = mk(1, 32'h1000, 0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h44,   0);
        tbl[10] = mk(1, 32'h8,    0, 0, 32'h0, 32'h0,    1, 1, 1, NOP,      0);
        tbl[11] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 1, 1, NOP,      0);
        tbl[12] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h33,   0);
        tbl[13] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'h33,   0);
        tbl[14] = mk(1, 32'h4,    0, 1, 32'h4, 32'hABCD, 0, 0, 0, 32'h33,   0);
        tbl[15] = mk(1, 32'h4,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'h33,   0);
        tbl[16] = mk(0, 32'h0,    0, 1, 32'h2, 32'h5555, 0, 0, 0, 32'h33,   0);
        tbl[17] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'hABCD, 1);
        tbl[18] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hABCD, 1);
        tbl[19] = mk(1, 32'h8,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hABCD, 1);
        tbl[20] = mk(1, 32'h0,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'hABCD, 1);
        tbl[21] = mk(1, 32'hC,    1, 0, 32'h0, 32'h0,    0, 1, 0, 32'h33,   1);
        tbl[22] = mk(1, 32'hC,    1, 0, 32'h0, 32'h0,    0, 1, 0, 32'h33,   1);
        tbl[23] = mk(1, 32'hC,    1, 0, 32'h0, 32'h0,    0, 1, 0, 32'h33,   1);
        tbl[24] = mk(1, 32'hC,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h33,   1);
        tbl[25] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h11,   1);
        tbl[26] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 1, 0, 32'h44,   1);
        tbl[27] = mk(0, 32'h0,    0, 0, 32'h0, 32'h0,    1, 0, 0, 32'h44,   1);

        reset = 1'b1; req = 1'b0; hold = 1'b0; ld = 1'b0;
        addr = '0; laddr = '0; ldata = '0;
        hist.delete();
        m_lerr = 1'b0;

        // Reset state
        sample();
        chk("reset rsp_valid", 32'(val2), 32'h0);
        chk("reset rd_data", dat2, NOP);
        chk("reset load_err", 32'(lerr4), 32'h0);
        advance();
        cycle();
        reset = 1'b0;
        cycle();

        // Preload every word so reads never see uninitialised storage
        for (int i = 0; i < int'(DEPTH); i++) begin
            ld = 1'b1; laddr = 32'(i) << 2; ldata = $urandom;
            cycle();
        end
        ld = 1'b0;

        // Directed vectors
        for (int i = 0; i < 28; i++) begin
            req = tbl[i].rq; addr = tbl[i].a; hold = tbl[i].h;
            ld = tbl[i].l; laddr = tbl[i].la; ldata = tbl[i].ldat;
            sample();
            chk($sformatf("tbl%0d ready", i), 32'(rdy2), 32'(tbl[i].x_rdy));
            chk($sformatf("tbl%0d valid", i), 32'(val2), 32'(tbl[i].x_val));
            chk($sformatf("tbl%0d err", i), 32'(err2), 32'(tbl[i].x_err));
            chk($sformatf("tbl%0d data", i), dat2, tbl[i].x_dat);
            chk($sformatf("tbl%0d load_err", i), 32'(lerr2), 32'(tbl[i].x_lerr));
            advance();
        end
        req = 1'b0; hold = 1'b0; ld = 1'b0;

        // Reset with requests in flight
        req = 1'b1; addr = 32'h0; cycle();
        addr = 32'h4; cycle();
        req = 1'b0; reset = 1'b1;
        sample();
        chk("rst L2 valid", 32'(val2), 32'h0);
        chk("rst L2 data", dat2, NOP);
        chk("rst L4 valid", 32'(val4), 32'h0);
        chk("rst L4 data", dat4, NOP);
        chk("rst load_err", 32'(lerr2), 32'h0);
        advance();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        req = 1'b1; addr = 32'h4; cycle();
        req = 1'b0; cycle();
        sample();
        chk("post-rst L2 valid", 32'(val2), 32'h1);
        chk("post-rst L2 data", dat2, 32'hABCD);
        advance();
        for (int i = 0; i < 4; i++) cycle();

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            hold  = ($urandom_range(0, 7) == 0);
            ld    = !reset && ($urandom_range(0, 7) == 0);
            laddr = ($urandom_range(0, 31) == 0) ? $urandom : (32'($urandom_range(0, DEPTH-1)) << 2);
            ldata = $urandom;
            req   = ($urandom_range(0, 3) != 0);
            r     = int'($urandom_range(0, 15));
            case (r)
                0:       addr = $urandom;
                1:       addr = (32'($urandom_range(0, DEPTH-1)) << 2) | 32'($urandom_range(1, 3));
                2:       addr = (32'(DEPTH) << 2) + (32'($urandom_range(0, 3)) << 2);
                3:       addr = (32'(DEPTH) << 2) - 32'h4;
                default: addr = 32'($urandom_range(0, DEPTH-1)) << 2;
            endcase
            cycle();
        end
        reset = 1'b0; req = 1'b0; hold = 1'b0; ld = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
